// File: rtl/morse_symbol_timer.sv
// Morse timing front end: classifies key presses as dot/dash/illegal and
// times the idle gap after each symbol to mark character and word ends.
module morse_symbol_timer #(
  // Defaults mirror DASH/ILLEGAL_SYMBOL/CHAR/WORD_TICK_COUNT_C in morse_decoder_pkg.
  parameter int unsigned DASH_TICKS    = 30_000_000,
  parameter int unsigned ILLEGAL_TICKS = 100_000_000,
  parameter int unsigned CHAR_TICKS    = 175_000_000,
  parameter int unsigned WORD_TICKS    = 250_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_db,
  output logic dot_o,
  output logic dash_o,
  output logic illegal_o,
  output logic char_end_o,
  output logic word_end_o,
  output logic pressed_o
);

  localparam int unsigned MaxTicks = (ILLEGAL_TICKS > WORD_TICKS) ? ILLEGAL_TICKS : WORD_TICKS;
  localparam int unsigned CW       = $clog2(MaxTicks + 1);

  localparam logic [CW-1:0] DashC    = CW'(DASH_TICKS);
  localparam logic [CW-1:0] IllegalC = CW'(ILLEGAL_TICKS);
  localparam logic [CW-1:0] CharC    = CW'(CHAR_TICKS);
  localparam logic [CW-1:0] WordC    = CW'(WORD_TICKS);
  localparam logic [CW-1:0] OneC     = CW'(1);

  typedef enum logic [1:0] {
    StWait  = 2'd0,
    StPress = 2'd1,
    StGap   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          dot_q, dot_d;
  logic          dash_q, dash_d;
  logic          illegal_q, illegal_d;
  logic          char_end_q, char_end_d;
  logic          word_end_q, word_end_d;
  logic          pressed_q, pressed_d;

  // Next-state, shared counter and event decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dot_d      = 1'b0;
    dash_d     = 1'b0;
    illegal_d  = 1'b0;
    char_end_d = 1'b0;
    word_end_d = 1'b0;
    cnt_inc    = cnt_q + OneC;

    unique case (state_q)
      StWait: begin
        if (btn_db) begin
          state_d = StPress;
          cnt_d   = OneC;
        end else begin
          cnt_d = '0;
        end
      end
      StPress: begin
        if (btn_db) begin
          // Saturate so an over-long press can never wrap back to a dot.
          cnt_d = (cnt_q >= IllegalC) ? IllegalC : cnt_inc;
        end else begin
          if (cnt_q < DashC) begin
            dot_d = 1'b1;
          end else if (cnt_q < IllegalC) begin
            dash_d = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
          // The release sample is the first gap sample.
          state_d = StGap;
          cnt_d   = OneC;
        end
      end
      StGap: begin
        if (btn_db) begin
          // A press on the boundary edge wins over the gap event.
          state_d = StPress;
          cnt_d   = OneC;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CharC) begin
            char_end_d = 1'b1;
          end
          if (cnt_inc == WordC) begin
            word_end_d = 1'b1;
            state_d    = StWait;
            cnt_d      = '0;
          end
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase

    pressed_d = (state_d == StPress);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWait;
      cnt_q      <= '0;
      dot_q      <= 1'b0;
      dash_q     <= 1'b0;
      illegal_q  <= 1'b0;
      char_end_q <= 1'b0;
      word_end_q <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dot_q      <= dot_d;
      dash_q     <= dash_d;
      illegal_q  <= illegal_d;
      char_end_q <= char_end_d;
      word_end_q <= word_end_d;
      pressed_q  <= pressed_d;
    end
  end

  assign dot_o      = dot_q;
  assign dash_o     = dash_q;
  assign illegal_o  = illegal_q;
  assign char_end_o = char_end_q;
  assign word_end_o = word_end_q;
  assign pressed_o  = pressed_q;

endmodule

// File: tb/tb_morse_symbol_timer.sv
// Bench for morse_symbol_timer: key-level sequences checked every cycle
// against expectations derived from press/gap run lengths.
module tb_morse_symbol_timer;

  localparam int unsigned Dash    = 3;
  localparam int unsigned Illegal = 6;
  localparam int unsigned Char    = 10;
  localparam int unsigned Word    = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_db;
  logic dot_o, dash_o, illegal_o, char_end_o, word_end_o, pressed_o;

  int checks = 0;
  int errors = 0;

  // Key level for each clock edge of the next sequence, from just after reset.
  bit          seq[$];
  logic [5:0]  exp_v[$];

  morse_symbol_timer #(
    .DASH_TICKS   (Dash),
    .ILLEGAL_TICKS(Illegal),
    .CHAR_TICKS   (Char),
    .WORD_TICKS   (Word)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_db    (btn_db),
    .dot_o     (dot_o),
    .dash_o    (dash_o),
    .illegal_o (illegal_o),
    .char_end_o(char_end_o),
    .word_end_o(word_end_o),
    .pressed_o (pressed_o)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {dot_o, dash_o, illegal_o, char_end_o, word_end_o, pressed_o};
  endfunction

  task automatic check(input string tag, input int idx, input logic [5:0] obs,
                       input logic [5:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s edge %0d: got {dot,dash,ill,char,word,pr}=%b expected %b",
             tag, idx, obs, expv);
    end
  endtask

  task automatic push_run(input bit level, input int n);
    for (int i = 0; i < n; i++) seq.push_back(level);
  endtask

  // Expected outputs after each edge, from run lengths of the key level.
  task automatic build_model();
    int n;
    n = seq.size();
    exp_v.delete();
    for (int e = 0; e < n; e++) exp_v.push_back({5'b0, seq[e]});
    for (int e = 1; e < n; e++) begin
      if (!seq[e] && seq[e-1]) begin
        int len;
        int gap;
        int j;
        len = 0;
        j = e - 1;
        while (j >= 0 && seq[j]) begin
          len++;
          j--;
        end
        if (len < Dash)         exp_v[e][5] = 1'b1;
        else if (len < Illegal) exp_v[e][4] = 1'b1;
        else                    exp_v[e][3] = 1'b1;
        gap = 0;
        j = e;
        while (j < n && !seq[j]) begin
          gap++;
          j++;
        end
        if (gap >= Char && e + Char - 1 < n) exp_v[e + Char - 1][2] = 1'b1;
        if (gap >= Word && e + Word - 1 < n) exp_v[e + Word - 1][1] = 1'b1;
      end
    end
  endtask

  // Releases reset, plays seq edge by edge and checks each edge.
  task automatic play(input string tag);
    build_model();
    for (int e = 0; e < seq.size(); e++) begin
      @(negedge clk);
      rst_n  = 1'b1;
      btn_db = seq[e];
      @(posedge clk);
      #1;
      check(tag, e, outs(), exp_v[e]);
    end
    seq.delete();
  endtask

  // Asynchronous reset mid-cycle; key level left untouched.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_async"}, 0, outs(), 6'b0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_hold"}, 1, outs(), 6'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_db = 1'b0;
    #1;
    check("reset", 0, outs(), 6'b0);
    repeat (2) @(posedge clk);

    push_run(1, 2);  push_run(0, 20); play("dot2_word");
    apply_reset("r1");
    push_run(1, 1);  push_run(0, 5);  play("dot1");
    apply_reset("r2");
    push_run(1, 3);  push_run(0, 4);  push_run(1, 5); push_run(0, 4); play("dash3_dash5");
    apply_reset("r3");
    push_run(1, 6);  push_run(0, 3);  push_run(1, 40); push_run(0, 4); play("illegal");
    apply_reset("r4");
    push_run(1, 1);  push_run(0, 12); push_run(1, 4); push_run(0, 3);
    push_run(1, 2);  push_run(0, 9);  push_run(1, 4); push_run(0, 20); play("char_gap");
    apply_reset("r5");
    push_run(1, 2);  push_run(0, 9);  push_run(1, 2); push_run(0, 20); play("press_at_char");
    apply_reset("r6");
    push_run(1, 2);  push_run(0, 14); push_run(1, 1); push_run(0, 16); play("press_at_word");
    apply_reset("r7");
    // Idle, then reset lands inside a press that would have become a dash.
    push_run(0, 300); push_run(1, 2); play("idle_press");
    apply_reset("mid_press");
    push_run(1, 2);  push_run(0, 20); play("after_reset");
    apply_reset("r8");

    for (int r = 0; r < 6; r++) begin
      push_run(0, $urandom_range(0, 3));
      for (int s = 0; s < 8; s++) begin
        push_run(1, $urandom_range(1, 45));
        push_run(0, $urandom_range(1, 25));
      end
      push_run(0, 16);
      play("random");
      apply_reset("rr");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
